vc_alloc_ctrl_20: RTL
=====================

Name: vc_alloc_ctrl_20

Overview:
- Output-VC allocation controller for the router VC allocator: 5 ports x 4 VCs = 20 input VCs competing for 20 output VCs.
- Per output VC: tracks free/busy state and owner, and runs a round-robin arbiter over the input VCs requesting it.
- Resolves input-side conflicts and issues registered one-cycle grant pulses.
- The request matrix is internally transposed (input-major to output-major) to feed the per-output-VC arbiters.

Parameters:
- N, 20, number of input VCs and output VCs; fixed at 20 (5 ports x 4 VCs)
- IDX_W, 5, width of a VC index

Ports:
- clk  input  1  single clock; all state on rising edge
- rstn  input  1  asynchronous active-low reset
- req  input  400  req[20*i+j]=1: input VC i requests output VC j; level, held until granted
- rel  input  20  rel[j]=1 pulse: owner of output VC j sent its tail flit; free VC j
- gnt  output  400  gnt[20*i+j]=1: one-cycle pulse, output VC j granted to input VC i; registered
- ovc_busy  output  20  ovc_busy[j]=1: output VC j currently allocated
- ovc_owner  output  100  ovc_owner[5*j+:5]=owning input VC index of j; 0 when free

Behaviour:
- Reset (rstn low, asynchronous): gnt=0, ovc_busy=0, ovc_owner=0, all round-robin pointers ptr_j=0. Reset mid-operation drops all allocations; no grant is issued in the cycle after release of reset unless requests are sampled.
- Per output VC j, two states:
  - FREE -> BUSY: on a committed grant.
  - BUSY -> FREE: when rel[j]=1.
- Stage A (combinational, each cycle):
  - For each FREE output VC j, select candidate winner w_j = first i with req[20*i+j]=1, searching i=ptr_j, ptr_j+1, ..., 19, 0, ..., ptr_j-1 (wrap at 19).
  - BUSY VCs produce no candidate.
- Stage B (input conflict resolution): if input VC i is the candidate of several output VCs in one cycle, only the lowest-index j is committed; the others are not granted.
- Commit (registered, next edge):
  - gnt[20*i+j]=1 for exactly one cycle.
  - ovc_busy[j]=1, ovc_owner[j]=i.
  - ptr_j=(i+1) mod 20.
  - Uncommitted candidates leave ptr_j unchanged.
- Latency: request visible at edge k produces gnt and ovc_busy asserted after edge k+1. Grants for a VC are never repeated while it is BUSY.
- Release:
  - rel[j] on a BUSY VC clears busy and owner at the next edge.
  - The VC is eligible for arbitration in the cycle after it reads FREE; there is no same-cycle release-and-regrant.
  - rel[j] on a FREE VC is ignored.
- Simultaneous events:
  - rel and new requests to the same j in one cycle: release wins, grant is deferred by one cycle.
  - Grants to different output VCs in the same cycle are independent, up to 20 total.
- Requests from input VC i must drop in the cycle after it sees gnt. If a request is still held afterwards, it may win further free output VCs (legal; upstream's responsibility).
- Invariants:
  - At most one 1 per gnt column j and per gnt row i in any cycle.
  - ovc_owner is valid only while ovc_busy=1.

Test Plan:
- Reset then single request req[20*3+7]=1 -> one cycle later gnt[67]=1 for one cycle, ovc_busy[7]=1, ovc_owner[7]=3, ptr_7=4.
- Input VCs 2, 5 and 18 all request output VC 0 (ptr=0) with a rel[0] pulse after each grant -> grants in order 2, 5, 18, then wrap back to 2; each grant comes two cycles after the previous one.
- Input VC 4 requests output VCs 1, 6 and 9 simultaneously, all free -> only gnt[20*4+1]; ptr_6 and ptr_9 unchanged; VCs 6 and 9 stay FREE.
- Output VC 10 busy (owner 7), input VC 11 requests it, rel[10] pulsed -> no grant in the release cycle; gnt[20*11+10] one cycle after ovc_busy[10] falls.
- rel[12] pulsed while VC 12 is FREE -> no state change; a rstn pulse mid-stream with 20 busy VCs -> all outputs 0 immediately, asynchronously.
- Randomised 10k cycles with a scoreboard -> per-cycle row/column one-hot on gnt, no grant to a busy VC, and every persistent requester granted within 20 release cycles.

Source files
------------

// File: rtl/vc_alloc_ctrl_20.sv
// Output-VC allocation controller: 20 input VCs compete for 20 output VCs.
// Each output VC keeps a busy flag, an owner and a round-robin pointer. A free
// output VC picks a candidate among its requesters (stage A); an input VC that
// is the candidate of several output VCs keeps only the lowest-index one
// (stage B). Commits are registered and appear as one-cycle grant pulses.
module vc_alloc_ctrl_20 #(
    parameter int N     = 20,
    parameter int IDX_W = 5
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N*N-1:0]     req,
    input  logic [N-1:0]       rel,
    output logic [N*N-1:0]     gnt,
    output logic [N-1:0]       ovc_busy,
    output logic [N*IDX_W-1:0] ovc_owner
);

    logic [N-1:0]     busy_q, busy_d;
    logic [IDX_W-1:0] owner_q [N];
    logic [IDX_W-1:0] owner_d [N];
    logic [IDX_W-1:0] ptr_q   [N];
    logic [IDX_W-1:0] ptr_d   [N];
    logic [N*N-1:0]   gnt_q, gnt_d;

    // req_col[j][i] is req[N*i+j]: output-major view of the request matrix
    logic [N-1:0]     req_col  [N];
    logic [N-1:0]     cand_vld;
    logic [IDX_W-1:0] cand_idx [N];
    logic [N-1:0]     commit;
    logic [N-1:0]     taken;

    // Transpose the input-major request matrix into per-output-VC columns
    always_comb begin
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                req_col[j][i] = req[N*i+j];
            end
        end
    end

    // Stage A: round-robin candidate search per free output VC, starting at ptr
    always_comb begin
        int idx;
        idx = 0;
        for (int j = 0; j < N; j++) begin
            cand_vld[j] = 1'b0;
            cand_idx[j] = '0;
            if (!busy_q[j]) begin
                for (int k = 0; k < N; k++) begin
                    idx = int'(ptr_q[j]) + k;
                    if (idx >= N) idx = idx - N;
                    if (!cand_vld[j] && req_col[j][idx]) begin
                        cand_vld[j] = 1'b1;
                        cand_idx[j] = IDX_W'(idx);
                    end
                end
            end
        end
    end

    // Stage B: each input VC keeps only its lowest-index output VC candidate
    always_comb begin
        taken  = '0;
        commit = '0;
        for (int j = 0; j < N; j++) begin
            if (cand_vld[j] && !taken[cand_idx[j]]) begin
                commit[j]          = 1'b1;
                taken[cand_idx[j]] = 1'b1;
            end
        end
    end

    // Next state: release of a busy VC takes priority; a busy VC never commits
    always_comb begin
        busy_d = busy_q;
        gnt_d  = '0;
        for (int j = 0; j < N; j++) begin
            owner_d[j] = owner_q[j];
            ptr_d[j]   = ptr_q[j];
            if (busy_q[j] && rel[j]) begin
                busy_d[j]  = 1'b0;
                owner_d[j] = '0;
            end else if (commit[j]) begin
                busy_d[j]  = 1'b1;
                owner_d[j] = cand_idx[j];
                ptr_d[j]   = (cand_idx[j] == IDX_W'(N-1)) ? '0 : cand_idx[j] + IDX_W'(1);
                gnt_d[N*int'(cand_idx[j]) + j] = 1'b1;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_q <= '0;
            gnt_q  <= '0;
            for (int j = 0; j < N; j++) begin
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            busy_q <= busy_d;
            gnt_q  <= gnt_d;
            for (int j = 0; j < N; j++) begin
                owner_q[j] <= owner_d[j];
                ptr_q[j]   <= ptr_d[j];
            end
        end
    end

    assign gnt      = gnt_q;
    assign ovc_busy = busy_q;

    // Flatten owner registers onto the output bus
    always_comb begin
        for (int j = 0; j < N; j++) begin
            ovc_owner[IDX_W*j +: IDX_W] = owner_q[j];
        end
    end

endmodule
